// File: rtl/operand_loader_if.sv
// Handshake bundle between the serial operand source and operand_loader.
// master drives the serial lanes and controls; slave is the loader.
interface operand_loader_if #(
  parameter int WIDTH = 6
);
  logic             ena;
  logic             sframe;
  logic             sdata_a;
  logic             sdata_b;
  logic             clr_err;
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             out_valid;
  logic             busy;
  logic             err;
  logic [7:0]       load_cnt;

  modport master (
    output ena, sframe, sdata_a, sdata_b, clr_err,
    input  ina, inb, out_valid, busy, err, load_cnt
  );

  modport slave (
    input  ena, sframe, sdata_a, sdata_b, clr_err,
    output ina, inb, out_valid, busy, err, load_cnt
  );
endinterface

// File: rtl/operand_loader.sv
// Two-lane MSB-first serial-to-parallel operand loader with framing-error detection.
// Define OPERAND_LOADER_PARITY_EN to append one even-parity bit per lane to every frame.
//
// state    | meaning
// IDLE     | waiting for sframe to start a frame
// SHIFT    | collecting bits of the current frame
// WAIT_END | frame complete, waiting for sframe to drop
module operand_loader #(
  parameter int WIDTH = 6
) (
  input  logic            clk,
  input  logic            reset,
  operand_loader_if.slave bus
);

`ifdef OPERAND_LOADER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int            CW       = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_a_q, shadow_a_d;
  logic [WIDTH-1:0] shadow_b_q, shadow_b_d;
  logic [WIDTH-1:0] ina_q, ina_d;
  logic [WIDTH-1:0] inb_q, inb_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [7:0]       load_cnt_q, load_cnt_d;

  logic [WIDTH-1:0] shift_a, shift_b;
  logic [WIDTH-1:0] cand_a, cand_b;
  logic             cand_ok;
  logic             last_bit;
  logic             err_ev;

  assign shift_a = WIDTH'({shadow_a_q, bus.sdata_a});
  assign shift_b = WIDTH'({shadow_b_q, bus.sdata_b});

`ifdef OPERAND_LOADER_PARITY_EN
  // Incoming bit is the parity bit; shadows already hold all data bits.
  assign cand_a  = shadow_a_q;
  assign cand_b  = shadow_b_q;
  assign cand_ok = ((^shadow_a_q) == bus.sdata_a) && ((^shadow_b_q) == bus.sdata_b);
`else
  assign cand_a  = shift_a;
  assign cand_b  = shift_b;
  assign cand_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_a_d  = shadow_a_q;
    shadow_b_d  = shadow_b_q;
    ina_d       = ina_q;
    inb_d       = inb_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    load_cnt_d  = load_cnt_q;
    last_bit    = 1'b0;
    err_ev      = 1'b0;

    if (bus.ena) begin
      case (state_q)
        IDLE: begin
          if (bus.sframe) begin
            shadow_a_d = shift_a;
            shadow_b_d = shift_b;
            cnt_d      = CW'(1);
            state_d    = SHIFT;
            last_bit   = (NBITS == 1);
          end
        end
        SHIFT: begin
          if (bus.sframe) begin
            shadow_a_d = shift_a;
            shadow_b_d = shift_b;
            cnt_d      = cnt_q + 1'b1;
            last_bit   = (cnt_q == LAST_CNT);
          end else begin
            err_ev  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        WAIT_END: begin
          if (bus.sframe) begin
            err_ev = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase

      if (last_bit) begin
        state_d = WAIT_END;
        if (cand_ok) begin
          ina_d       = cand_a;
          inb_d       = cand_b;
          out_valid_d = 1'b1;
          load_cnt_d  = load_cnt_q + 8'd1;
        end else begin
          err_ev = 1'b1;
        end
      end

      // A new error outranks a simultaneous clear.
      if (err_ev) begin
        err_d = 1'b1;
      end else if (bus.clr_err) begin
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_a_q  <= '0;
      shadow_b_q  <= '0;
      ina_q       <= '0;
      inb_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      load_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_a_q  <= shadow_a_d;
      shadow_b_q  <= shadow_b_d;
      ina_q       <= ina_d;
      inb_q       <= inb_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  // Gated by ena so a stalled pulse cycle never shows a valid.
  assign bus.out_valid = out_valid_q & bus.ena;
  assign bus.ina       = ina_q;
  assign bus.inb       = inb_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;
  assign bus.load_cnt  = load_cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: frame-level behavioural model checked every
// cycle, plus directed frames with literal expectations.
module tb_operand_loader;
  localparam int WIDTH = 6;
`ifdef OPERAND_LOADER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N = WIDTH + P;

  logic clk = 1'b0;
  logic reset = 1'b1;

  operand_loader_if #(.WIDTH(WIDTH)) bus ();
  operand_loader #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: phase 0 idle, 1 collecting, 2 frame done awaiting sframe low.
  int          m_phase = 0;
  int          m_nb = 0;
  int unsigned m_acc_a = 0, m_acc_b = 0;
  int unsigned m_ina = 0, m_inb = 0, m_cnt = 0;
  bit          m_err = 0, m_pulse = 0, m_live = 0;

  always @(posedge clk) begin
    bit          ev;
    bit          ok;
    int unsigned da, db;
    m_live = 1;
    if (reset) begin
      m_phase = 0; m_nb = 0; m_acc_a = 0; m_acc_b = 0;
      m_ina = 0; m_inb = 0; m_cnt = 0; m_err = 0; m_pulse = 0;
    end else if (!bus.ena) begin
      m_pulse = 0;
    end else begin
      ev = 0;
      m_pulse = 0;
      if (m_phase == 0 && bus.sframe) begin
        m_phase = 1; m_nb = 0; m_acc_a = 0; m_acc_b = 0;
      end else if (m_phase == 1 && !bus.sframe) begin
        ev = 1; m_phase = 0;
      end else if (m_phase == 2) begin
        if (bus.sframe) ev = 1;
        else m_phase = 0;
      end
      if (m_phase == 1 && bus.sframe) begin
        m_acc_a = m_acc_a * 2 + 32'(bus.sdata_a);
        m_acc_b = m_acc_b * 2 + 32'(bus.sdata_b);
        m_nb++;
        if (m_nb == N) begin
          m_phase = 2;
          da = m_acc_a >> P;
          db = m_acc_b >> P;
          ok = 1;
          if (P == 1)
            ok = ((m_acc_a % 2) == ($countones(da) % 2)) && ((m_acc_b % 2) == ($countones(db) % 2));
          if (ok) begin
            m_ina = da; m_inb = db; m_cnt = (m_cnt + 1) % 256; m_pulse = 1;
          end else begin
            ev = 1;
          end
        end
      end
      if (ev) m_err = 1;
      else if (bus.clr_err) m_err = 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_ina", 32'(bus.ina), m_ina);
      chk("m_inb", 32'(bus.inb), m_inb);
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_pulse && bus.ena));
      chk("m_busy", 32'(bus.busy), 32'(m_phase != 0));
      chk("m_err", 32'(bus.err), 32'(m_err));
      chk("m_load_cnt", 32'(bus.load_cnt), m_cnt);
    end
  end

  function automatic logic [31:0] fw(input logic [5:0] d);
    if (P == 1) return {25'd0, d, ^d};
    return {26'd0, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] wa, input logic [31:0] wb, input int n,
                      input int stall_at, input int stall_len);
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.ena = 1'b0;
          bus.sframe = 1'b1;
          bus.sdata_a = 1'($urandom_range(0, 1));
          bus.sdata_b = 1'($urandom_range(0, 1));
          step();
        end
      end
      bus.ena = 1'b1;
      bus.sframe = 1'b1;
      bus.sdata_a = wa[n-1-k];
      bus.sdata_b = wb[n-1-k];
      step();
    end
    bus.sframe = 1'b0;
    bus.sdata_a = 1'b0;
    bus.sdata_b = 1'b0;
  endtask

  initial begin
    bus.ena = 1'b1; bus.sframe = 1'b0; bus.sdata_a = 1'b0; bus.sdata_b = 1'b0;
    bus.clr_err = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ina", 32'(bus.ina), 0);
    chk("rst_load_cnt", 32'(bus.load_cnt), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    step();

    send(fw(6'b101101), fw(6'b010011), N, -1, 0);
    @(negedge clk);
    chk("f1_pulse", 32'(bus.out_valid), 1);
    chk("f1_ina", 32'(bus.ina), 45);
    chk("f1_inb", 32'(bus.inb), 19);
    chk("f1_cnt", 32'(bus.load_cnt), 1);
    chk("f1_err", 32'(bus.err), 0);
    step();
    @(negedge clk);
    chk("f1_pulse_end", 32'(bus.out_valid), 0);
    chk("f1_busy_low", 32'(bus.busy), 0);
    step();

    send(32'b1010, 32'b0110, 4, -1, 0);
    step();
    @(negedge clk);
    chk("short_err", 32'(bus.err), 1);
    chk("short_ina", 32'(bus.ina), 45);
    chk("short_inb", 32'(bus.inb), 19);
    chk("short_idle", 32'(bus.busy), 0);
    step();

    send(fw(6'b110010), fw(6'b001101), N, -1, 0);
    @(negedge clk);
    chk("f2_ina", 32'(bus.ina), 50);
    chk("f2_inb", 32'(bus.inb), 13);
    chk("f2_err_sticky", 32'(bus.err), 1);
    chk("f2_cnt", 32'(bus.load_cnt), 2);
    step();

    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    @(negedge clk);
    chk("clr_err", 32'(bus.err), 0);
    step();

    send((fw(6'b011100) << 2) | 32'd3, (fw(6'b100011) << 2) | 32'd3, N + 2, -1, 0);
    @(negedge clk);
    chk("ovr_ina", 32'(bus.ina), 28);
    chk("ovr_inb", 32'(bus.inb), 35);
    chk("ovr_err", 32'(bus.err), 1);
    chk("ovr_cnt", 32'(bus.load_cnt), 3);
    step();
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;

    send(fw(6'b100110), fw(6'b011001), N, 2, 3);
    @(negedge clk);
    chk("stall_pulse", 32'(bus.out_valid), 1);
    chk("stall_ina", 32'(bus.ina), 38);
    chk("stall_inb", 32'(bus.inb), 25);
    chk("stall_cnt", 32'(bus.load_cnt), 4);
    step();

    send(fw(6'b111111), fw(6'b000001), N, -1, 0);
    bus.ena = 1'b0;
    @(negedge clk);
    chk("stall_in_pulse", 32'(bus.out_valid), 0);
    chk("sip_ina", 32'(bus.ina), 63);
    step();
    bus.ena = 1'b1;
    @(negedge clk);
    chk("no_stretch", 32'(bus.out_valid), 0);
    chk("sip_cnt", 32'(bus.load_cnt), 5);
    step();

    send(32'b101, 32'b011, 3, -1, 0);
    reset = 1'b1; step(); reset = 1'b0;
    @(negedge clk);
    chk("mrst_ina", 32'(bus.ina), 0);
    chk("mrst_cnt", 32'(bus.load_cnt), 0);
    chk("mrst_err", 32'(bus.err), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    step();
    send(fw(6'b000111), fw(6'b111000), N, -1, 0);
    @(negedge clk);
    chk("f3_ina", 32'(bus.ina), 7);
    chk("f3_inb", 32'(bus.inb), 56);
    chk("f3_cnt", 32'(bus.load_cnt), 1);
    step();

    send(32'b11, 32'b01, 2, -1, 0);
    step();
    send(32'b11, 32'b01, 2, -1, 0);
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    @(negedge clk);
    chk("clr_vs_err", 32'(bus.err), 1);
    step();

`ifdef OPERAND_LOADER_PARITY_EN
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    send({25'd0, 6'b101101, 1'b0}, {25'd0, 6'b010011, 1'b0}, 7, -1, 0);
    @(negedge clk);
    chk("par_bad_pulse", 32'(bus.out_valid), 0);
    chk("par_bad_err", 32'(bus.err), 1);
    chk("par_bad_ina", 32'(bus.ina), 7);
    chk("par_bad_cnt", 32'(bus.load_cnt), 1);
    step();
    send({25'd0, 6'b101101, 1'b0}, {25'd0, 6'b010011, 1'b1}, 7, -1, 0);
    @(negedge clk);
    chk("par_ok_pulse", 32'(bus.out_valid), 1);
    chk("par_ok_ina", 32'(bus.ina), 45);
    chk("par_ok_inb", 32'(bus.inb), 19);
    chk("par_ok_cnt", 32'(bus.load_cnt), 2);
    step();
`endif

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
